// File: rtl/text_line_buffer.sv
// Editable single-line character buffer feeding the text display: accepts
// characters and edit commands, scrolls left when full, commits on ENTER.
module text_line_buffer #(
    parameter int CHARS        = 10,
    parameter int CW           = 6,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_cmd,
    input  logic [CW-1:0]         in_char,
    output logic [CHARS*CW-1:0]   text_line,
    output logic [CHARS*CW-1:0]   committed_line,
    output logic                  line_done,
    output logic [3:0]            len,
    output logic [3:0]            cursor_pos,
    output logic                  cursor_on,
    output logic                  err
);

    localparam logic [CW-1:0] EMPTY     = {CW{1'b1}};
    localparam int            CNT_W     = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [1:0]    CMD_CHAR  = 2'b00;
    localparam logic [1:0]    CMD_BKSP  = 2'b01;
    localparam logic [1:0]    CMD_CLEAR = 2'b10;
    localparam logic [1:0]    CMD_ENTER = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic [3:0]            len_reg, len_next;
    logic [CHARS*CW-1:0]   committed_reg;
    logic                  err_reg;
    logic                  cursor_on_reg;
    logic [CNT_W-1:0]      blink_cnt_reg;

    logic accept;
    logic char_ok;
    logic full;
    logic do_char;
    logic do_bksp;
    logic do_clear;
    logic do_enter;
    logic wipe;

    assign in_ready = (state_reg == IDLE);
    assign accept   = in_valid & in_ready;
    assign char_ok  = (32'(in_char) < 32'd36);
    assign full     = (len_reg == 4'(CHARS));
    assign do_char  = accept && (in_cmd == CMD_CHAR) && char_ok;
    assign do_bksp  = accept && (in_cmd == CMD_BKSP);
    assign do_clear = accept && (in_cmd == CMD_CLEAR);
    assign do_enter = accept && (in_cmd == CMD_ENTER);
    // The COMMIT cycle empties the line exactly like CLEAR does.
    assign wipe     = (state_reg == COMMIT) || do_clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (do_enter) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        len_next = len_reg;
        if (wipe) begin
            len_next = 4'd0;
        end else if (do_char && !full) begin
            len_next = len_reg + 4'd1;
        end else if (do_bksp && (len_reg != 4'd0)) begin
            len_next = len_reg - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_reg <= 4'd0;
        end else begin
            len_reg <= len_next;
        end
    end

    // Each slot owns its register; the full-line scroll takes its neighbour
    // on the right, and the last slot takes the incoming character.
    generate
        for (genvar gi = 0; gi < CHARS; gi++) begin : g_slot
            logic [CW-1:0] slot_reg, slot_next, shift_src;

            if (gi < CHARS - 1) begin : g_mid
                assign shift_src = text_line[(gi+1)*CW +: CW];
            end else begin : g_last
                assign shift_src = in_char;
            end

            always_comb begin
                slot_next = slot_reg;
                if (wipe) begin
                    slot_next = EMPTY;
                end else if (do_char) begin
                    if (full) begin
                        slot_next = shift_src;
                    end else if (len_reg == 4'(gi)) begin
                        slot_next = in_char;
                    end
                end else if (do_bksp && (len_reg == 4'(gi + 1))) begin
                    slot_next = EMPTY;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_reg <= EMPTY;
                end else begin
                    slot_reg <= slot_next;
                end
            end

            assign text_line[gi*CW +: CW] = slot_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            committed_reg <= {(CHARS*CW){1'b1}};
            err_reg       <= 1'b0;
        end else begin
            if (do_enter) begin
                committed_reg <= text_line;
            end
            err_reg <= accept && (in_cmd == CMD_CHAR) && !char_ok;
        end
    end

    // Editing keeps the cursor solid; ENTER does not touch the blink phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_reg <= '0;
            cursor_on_reg <= 1'b1;
        end else if (accept && (in_cmd != CMD_ENTER)) begin
            blink_cnt_reg <= '0;
            cursor_on_reg <= 1'b1;
        end else if (blink_cnt_reg == CNT_W'(BLINK_CYCLES - 1)) begin
            blink_cnt_reg <= '0;
            cursor_on_reg <= ~cursor_on_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end

    assign committed_line = committed_reg;
    assign line_done      = (state_reg == COMMIT);
    assign len            = len_reg;
    assign cursor_pos     = (len_reg >= 4'(CHARS - 1)) ? 4'(CHARS - 1) : len_reg;
    assign cursor_on      = cursor_on_reg;
    assign err            = err_reg;

endmodule

// File: tb/tb_text_line_buffer.sv
// Scoreboard bench for text_line_buffer: a queue-based line model predicts
// every post-edge output state; a monitor compares them a few ns after each edge.
module tb_text_line_buffer;

    localparam int CHARS = 10;
    localparam int CW    = 6;
    localparam int BLINK = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          in_cmd;
    logic [CW-1:0]       in_char;
    logic [CHARS*CW-1:0] text_line;
    logic [CHARS*CW-1:0] committed_line;
    logic                line_done;
    logic [3:0]          len;
    logic [3:0]          cursor_pos;
    logic                cursor_on;
    logic                err;

    text_line_buffer #(
        .CHARS(CHARS), .CW(CW), .BLINK_CYCLES(BLINK)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_cmd(in_cmd), .in_char(in_char), .text_line(text_line),
        .committed_line(committed_line), .line_done(line_done), .len(len),
        .cursor_pos(cursor_pos), .cursor_on(cursor_on), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned         cyc;
        logic [CHARS*CW-1:0] line;
        logic [CHARS*CW-1:0] comm;
        logic [3:0]          len;
        logic [3:0]          cpos;
        logic                done;
        logic                err;
        logic                ready;
        logic                on;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // Reference model: the line is a queue of codes, the rest plain variables.
    int          m_line[$];
    logic [CHARS*CW-1:0] m_comm;
    bit          m_commit;
    int          m_cnt;
    bit          m_on;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, want);
        end
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #3;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            check("stale_expectation", 64'(e.cyc), 64'(cyc));
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check("text_line",      64'(text_line),      64'(e.line));
            check("committed_line", 64'(committed_line), 64'(e.comm));
            check("len",            64'(len),            64'(e.len));
            check("cursor_pos",     64'(cursor_pos),     64'(e.cpos));
            check("line_done",      64'(line_done),      64'(e.done));
            check("err",            64'(err),            64'(e.err));
            check("in_ready",       64'(in_ready),       64'(e.ready));
            check("cursor_on",      64'(cursor_on),      64'(e.on));
        end
    end

    // Drive one cycle of inputs, advance the model over the coming edge and
    // queue the state the DUT must show after it.
    task automatic step(input bit r, input bit v, input logic [1:0] c, input int ch);
        exp_t e;
        bit   acc;
        bit   m_err;
        rst      = r;
        in_valid = v;
        in_cmd   = c;
        in_char  = CW'(ch);
        m_err    = 1'b0;
        acc      = 1'b0;
        if (r) begin
            m_line.delete();
            m_comm   = '1;
            m_commit = 1'b0;
            m_cnt    = 0;
            m_on     = 1'b1;
        end else begin
            acc = v && !m_commit;
            if (m_commit) begin
                m_line.delete();
                m_commit = 1'b0;
            end
            if (acc) begin
                case (c)
                    2'b00: begin
                        if (ch < 36) begin
                            if (m_line.size() == CHARS) void'(m_line.pop_front());
                            m_line.push_back(ch);
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                    2'b01: if (m_line.size() > 0) void'(m_line.pop_back());
                    2'b10: m_line.delete();
                    default: begin
                        for (int i = 0; i < CHARS; i++)
                            m_comm[i*CW +: CW] = (i < m_line.size()) ? CW'(m_line[i]) : '1;
                        m_commit = 1'b1;
                    end
                endcase
            end
            if (acc && c != 2'b11) begin
                m_cnt = 0;
                m_on  = 1'b1;
            end else if (m_cnt == BLINK - 1) begin
                m_cnt = 0;
                m_on  = !m_on;
            end else begin
                m_cnt++;
            end
        end
        e.cyc = cyc + 1;
        for (int i = 0; i < CHARS; i++)
            e.line[i*CW +: CW] = (i < m_line.size()) ? CW'(m_line[i]) : '1;
        e.comm  = m_comm;
        e.len   = 4'(m_line.size());
        e.cpos  = (m_line.size() >= CHARS - 1) ? 4'(CHARS - 1) : 4'(m_line.size());
        e.done  = m_commit;
        e.err   = m_err;
        e.ready = !m_commit;
        e.on    = m_on;
        sb.push_back(e);
        if (acc || r)
            $display("txn cycle %0d rst=%0d cmd=%0d char=%0d -> len=%0d", cyc, r, c, ch, m_line.size());
        @(posedge clk);
        #1;
    endtask

    task automatic type_char(input int ch);
        step(1'b0, 1'b1, 2'b00, ch);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 0);
    endtask

    initial begin
        int pick;
        int code;
        rst = 1'b1; in_valid = 1'b0; in_cmd = 2'b00; in_char = '0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 2'b00, 0);
        step(1'b1, 1'b1, 2'b00, 5);
        idle(1);
        // Directed cases from the intended usage.
        type_char(1); type_char(2); type_char(3);
        step(1'b0, 1'b1, 2'b10, 0);
        for (int k = 0; k <= 10; k++) type_char(k);
        step(1'b0, 1'b1, 2'b10, 0);
        type_char(4); type_char(9);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 2'b01, 0);
        type_char(40);
        idle(2);
        type_char(7); type_char(8);
        step(1'b0, 1'b1, 2'b11, 0);
        type_char(5); type_char(5);
        idle(13);
        type_char(3);
        idle(6);
        step(1'b0, 1'b1, 2'b11, 0);
        step(1'b1, 1'b1, 2'b00, 2);
        idle(2);
        // Randomized traffic, including occasional resets.
        for (int n = 0; n < 1500; n++) begin
            pick = $urandom_range(0, 19);
            code = ($urandom_range(0, 9) == 0) ? $urandom_range(36, 63) : $urandom_range(0, 35);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 (pick < 12) ? 2'b00 : (pick < 16) ? 2'b01 : (pick < 18) ? 2'b10 : 2'b11,
                 code);
        end
        idle(1);
        repeat (3) @(posedge clk);
        #4;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
